// File: rtl/lockpick_core_param.sv
// rtl/lockpick_core_param.sv - parametrised combination-lock engine with per-guess hint, try counter and timed lockout
module lockpick_core_param #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 1000,
    localparam int CODE_W     = DIGITS * DIGIT_W,
    localparam int IDX_W      = $clog2(DIGITS + 1),
    localparam int TRY_W      = $clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               code_load,
    input  logic [CODE_W-1:0]  code_in,
    input  logic               guess_valid,
    input  logic [DIGIT_W-1:0] guess_digit,
    output logic               guess_ready,
    input  logic               abort,
    input  logic               relock,
    output logic               result_valid,
    output logic [IDX_W-1:0]   match_count,
    output logic [IDX_W-1:0]   digit_idx,
    output logic [TRY_W-1:0]   tries_left,
    output logic               unlocked,
    output logic               locked_out
);

    localparam int LCK_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    typedef enum logic [2:0] {
        NO_CODE,
        ARMED,
        CHECK,
        OPEN,
        LOCKOUT
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  secret_q, secret_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   hits_q, hits_d;
    logic [IDX_W-1:0]   match_q, match_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [LCK_W-1:0]   lock_q, lock_d;

    logic [DIGIT_W-1:0] secret_digit;
    logic               digit_hit;
    logic               last_digit;

    // Digit 0 sits in the most significant field of the secret.
    always_comb begin
        secret_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                secret_digit = secret_q[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign digit_hit  = (guess_digit == secret_digit);
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        state_d  = state_q;
        secret_d = secret_q;
        idx_d    = idx_q;
        hits_d   = hits_q;
        match_d  = match_q;
        tries_d  = tries_q;
        lock_d   = lock_q;
        case (state_q)
            NO_CODE: begin
                if (code_load) begin
                    secret_d = code_in;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (abort) begin
                    idx_d  = '0;
                    hits_d = '0;
                end else if (guess_valid) begin
                    hits_d = hits_q + IDX_W'(digit_hit);
                    if (last_digit) begin
                        idx_d   = IDX_W'(DIGITS);
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CHECK: begin
                match_d = hits_q;
                idx_d   = '0;
                hits_d  = '0;
                if (hits_q == IDX_W'(DIGITS)) begin
                    tries_d = TRY_W'(MAX_TRIES);
                    state_d = OPEN;
                end else if (tries_q <= TRY_W'(1)) begin
                    tries_d = '0;
                    lock_d  = LCK_W'(LOCKOUT_CYC - 1);
                    state_d = LOCKOUT;
                end else begin
                    tries_d = tries_q - TRY_W'(1);
                    state_d = ARMED;
                end
            end
            OPEN: begin
                if (code_load) begin
                    secret_d = code_in;
                    state_d  = ARMED;
                end else if (relock) begin
                    state_d = ARMED;
                end
            end
            LOCKOUT: begin
                if (lock_q == '0) begin
                    tries_d = TRY_W'(MAX_TRIES);
                    state_d = ARMED;
                end else begin
                    lock_d = lock_q - LCK_W'(1);
                end
            end
            default: state_d = NO_CODE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= NO_CODE;
            secret_q <= '0;
            idx_q    <= '0;
            hits_q   <= '0;
            match_q  <= '0;
            tries_q  <= TRY_W'(MAX_TRIES);
            lock_q   <= '0;
        end else begin
            state_q  <= state_d;
            secret_q <= secret_d;
            idx_q    <= idx_d;
            hits_q   <= hits_d;
            match_q  <= match_d;
            tries_q  <= tries_d;
            lock_q   <= lock_d;
        end
    end

    // The hint is presented straight from the accumulator during CHECK, then held.
    assign guess_ready  = (state_q == ARMED);
    assign result_valid = (state_q == CHECK);
    assign match_count  = result_valid ? hits_q : match_q;
    assign digit_idx    = idx_q;
    assign tries_left   = tries_q;
    assign unlocked     = (state_q == OPEN);
    assign locked_out   = (state_q == LOCKOUT);

endmodule

// File: tb/tb_lockpick_core_param.sv
// tb/tb_lockpick_core_param.sv - randomized and directed bench for lockpick_core_param against a queue-based lock model
module tb_lockpick_core_param;

    localparam int DG = 4;
    localparam int DW = 4;
    localparam int MT = 3;
    localparam int LC = 8;

    localparam int M_NONE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_CHECK = 2;
    localparam int M_OPEN  = 3;
    localparam int M_LOCK  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          code_load;
    logic [15:0]   code_in;
    logic          guess_valid;
    logic [3:0]    guess_digit;
    logic          guess_ready;
    logic          abort;
    logic          relock;
    logic          result_valid;
    logic [2:0]    match_count;
    logic [2:0]    digit_idx;
    logic [1:0]    tries_left;
    logic          unlocked;
    logic          locked_out;

    lockpick_core_param #(
        .DIGITS(DG), .DIGIT_W(DW), .MAX_TRIES(MT), .LOCKOUT_CYC(LC)
    ) dut (
        .clk(clk), .rst(rst), .code_load(code_load), .code_in(code_in),
        .guess_valid(guess_valid), .guess_digit(guess_digit), .guess_ready(guess_ready),
        .abort(abort), .relock(relock), .result_valid(result_valid),
        .match_count(match_count), .digit_idx(digit_idx), .tries_left(tries_left),
        .unlocked(unlocked), .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode;
    int m_secret[DG];
    int m_entry[$];
    int m_tries;
    int m_lock;
    int m_match;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_NONE;
        m_entry.delete();
        m_tries = MT;
        m_lock  = 0;
        m_match = 0;
        foreach (m_secret[i]) m_secret[i] = 0;
    endtask

    task automatic model_load(input logic [15:0] cin);
        for (int i = 0; i < DG; i++) m_secret[i] = (int'(cin) >> (DW * (DG - 1 - i))) & 15;
        m_mode = M_ARMED;
    endtask

    task automatic model_step(input logic gv, input logic [3:0] gd, input logic ab,
                              input logic rl, input logic cl, input logic [15:0] cin);
        case (m_mode)
            M_NONE: if (cl) model_load(cin);
            M_ARMED: begin
                if (ab) m_entry.delete();
                else if (gv) begin
                    m_entry.push_back(int'(gd));
                    if (m_entry.size() == DG) begin
                        m_match = 0;
                        foreach (m_entry[i]) if (m_entry[i] == m_secret[i]) m_match++;
                        m_mode = M_CHECK;
                    end
                end
            end
            M_CHECK: begin
                m_entry.delete();
                if (m_match == DG) begin
                    m_mode  = M_OPEN;
                    m_tries = MT;
                end else begin
                    m_tries--;
                    if (m_tries == 0) begin
                        m_mode = M_LOCK;
                        m_lock = LC;
                    end else m_mode = M_ARMED;
                end
            end
            M_OPEN: begin
                if (cl) model_load(cin);
                else if (rl) m_mode = M_ARMED;
            end
            M_LOCK: begin
                m_lock--;
                if (m_lock == 0) begin
                    m_mode  = M_ARMED;
                    m_tries = MT;
                end
            end
            default: m_mode = M_NONE;
        endcase
    endtask

    task automatic check_all();
        chk("guess_ready",  guess_ready,  m_mode == M_ARMED);
        chk("result_valid", result_valid, m_mode == M_CHECK);
        chk("match_count",  match_count,  m_match);
        chk("digit_idx",    digit_idx,    m_entry.size());
        chk("tries_left",   tries_left,   m_tries);
        chk("unlocked",     unlocked,     m_mode == M_OPEN);
        chk("locked_out",   locked_out,   m_mode == M_LOCK);
    endtask

    task automatic cyc(input logic gv, input logic [3:0] gd, input logic ab = 1'b0,
                       input logic rl = 1'b0, input logic cl = 1'b0, input logic [15:0] cin = 16'h0);
        @(negedge clk);
        check_all();
        guess_valid = gv;
        guess_digit = gd;
        abort       = ab;
        relock      = rl;
        code_load   = cl;
        code_in     = cin;
        @(posedge clk);
        model_step(gv, gd, ab, rl, cl, cin);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0);
    endtask

    task automatic guess(input logic [15:0] g);
        for (int i = 0; i < DG; i++) cyc(1'b1, 4'((g >> (DW * (DG - 1 - i))) & 16'hF));
    endtask

    task automatic clear_inputs();
        guess_valid = 1'b0;
        guess_digit = 4'h0;
        abort       = 1'b0;
        relock      = 1'b0;
        code_load   = 1'b0;
        code_in     = 16'h0;
    endtask

    // Reset is raised between clock edges so outputs must clear without a clock.
    task automatic async_reset();
        clear_inputs();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // no code loaded: guesses are ignored
        cyc(1'b1, 4'h1);
        cyc(1'b1, 4'h2);
        cyc(1'b1, 4'h3);
        idle(1);

        // correct guess unlocks
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h1234);
        guess(16'h1234);
        idle(2);

        // three wrong guesses lead to lockout and recovery
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        guess(16'h1939);
        idle(1);
        guess(16'h5555);
        idle(1);
        guess(16'h6666);
        idle(LC + 3);

        // abort beats a simultaneous handshake
        cyc(1'b1, 4'h1);
        cyc(1'b1, 4'h2);
        cyc(1'b1, 4'h3, 1'b1);
        idle(1);
        guess(16'h1234);
        idle(2);

        // code_load wins over relock in OPEN
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 16'hABCD);
        guess(16'hABCD);
        idle(2);

        // asynchronous reset mid-guess and mid-lockout
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h4321);
        cyc(1'b1, 4'h4);
        cyc(1'b1, 4'h3);
        async_reset();
        idle(1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h4321);
        for (int t = 0; t < MT; t++) begin
            guess(16'h0000);
            idle(1);
        end
        idle(3);
        async_reset();
        idle(2);

        // randomized play
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h2713);
        for (int n = 0; n < 600; n++) begin
            logic       gv, ab, rl, cl;
            logic [3:0] gd;
            logic [15:0] cin;
            gv  = ($urandom % 4) != 0;
            if (m_mode == M_ARMED && m_entry.size() < DG && ($urandom % 3) != 0)
                gd = 4'(m_secret[m_entry.size()]);
            else
                gd = 4'($urandom % 16);
            ab  = ($urandom % 25) == 0;
            rl  = ($urandom % 4) == 0;
            cl  = ($urandom % 8) == 0;
            cin = 16'($urandom);
            cyc(gv, gd, ab, rl, cl, cin);
        end
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
